meteor_update_scheduler: RTL and testbench

- Game-level controller for the Meteor Dodge VGA datapath: runs the game state machine and schedules per-frame meteor position updates into the meteor object datapath during vertical blanking.
- Consumes the frame strobe from the VGA sync generator and the pixel-collision flag from the colour mux.
- Issues one update command per meteor slot over a valid/ready handshake, and keeps the score.

---
 rtl/meteor_update_scheduler.sv | 107 ++++++++++
 tb/tb_meteor_update_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/meteor_update_scheduler.sv
// Meteor Dodge game controller: runs the game FSM, counts frames, and
// streams one update command per meteor slot into the object datapath
// during vertical blanking. Keeps a saturating score of completed rounds.
module meteor_update_scheduler #(
  parameter int NUM_METEORS = 4,
  parameter int SLOT_W      = 2,
  parameter int FRAME_DIV   = 2
) (
  input  logic              clkin,
  input  logic              gsr,
  input  logic              vblank_start,
  input  logic              collision,
  input  logic              start_btn,
  input  logic              upd_ready,
  output logic              upd_valid,
  output logic [SLOT_W-1:0] upd_slot,
  output logic              clear_objs,
  output logic [1:0]        game_state,
  output logic              game_over,
  output logic [15:0]       score,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_UPD  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam int                FC_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAME_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_METEORS - 1);

  state_t          state;
  logic            hit;
  logic [FC_W-1:0] frame_cnt;

  // state register is the game_state output directly
  assign game_state = state;

  // game FSM, update handshake, hit latch, frame divider and score
  always_ff @(posedge clkin or negedge gsr) begin
    if (!gsr) begin
      state      <= S_IDLE;
      upd_valid  <= 1'b0;
      upd_slot   <= '0;
      clear_objs <= 1'b0;
      game_over  <= 1'b0;
      score      <= 16'd0;
      overrun    <= 1'b0;
      hit        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      clear_objs <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          // start beats any coincident vblank; nothing else happens here
          if (start_btn) begin
            state      <= S_PLAY;
            clear_objs <= 1'b1;
            game_over  <= 1'b0;
            score      <= 16'd0;
            hit        <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
          end
        end
        S_PLAY: begin
          // a collision in the same cycle as vblank still ends the game
          if (vblank_start && (hit || collision)) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else begin
            if (collision) hit <= 1'b1;
            if (vblank_start) begin
              if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                upd_slot  <= '0;
                upd_valid <= 1'b1;
                state     <= S_UPD;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
        end
        S_UPD: begin
          if (collision)    hit     <= 1'b1;
          // a frame boundary mid-round means the datapath stalled too long
          if (vblank_start) overrun <= 1'b1;
          if (upd_ready) begin
            if (upd_slot == SLOT_LAST) begin
              upd_valid <= 1'b0;
              state     <= S_PLAY;
              if (score != 16'hFFFF) score <= score + 16'd1;
            end else begin
              upd_slot <= upd_slot + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meteor_update_scheduler.sv
// Bench for meteor_update_scheduler: directed scenarios followed by random
// stimulus, all checked every cycle against a rule-level game model.
module tb_meteor_update_scheduler;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int FD = 2;

  logic          clkin = 1'b0, gsr = 1'b0;
  logic          vblank_start = 1'b0, collision = 1'b0, start_btn = 1'b0, upd_ready = 1'b0;
  logic          upd_valid, clear_objs, game_over, overrun;
  logic [SW-1:0] upd_slot;
  logic [1:0]    game_state;
  logic [15:0]   score;

  meteor_update_scheduler #(.NUM_METEORS(N), .SLOT_W(SW), .FRAME_DIV(FD)) dut (
    .clkin(clkin), .gsr(gsr), .vblank_start(vblank_start), .collision(collision),
    .start_btn(start_btn), .upd_ready(upd_ready), .upd_valid(upd_valid),
    .upd_slot(upd_slot), .clear_objs(clear_objs), .game_state(game_state),
    .game_over(game_over), .score(score), .overrun(overrun)
  );

  always #5 clkin = ~clkin;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // game model: mode 0 idle, 1 play, 2 update, 3 over
  int m_st, m_slot, m_fc, m_score;
  bit m_valid, m_clr, m_hit, m_ovr, m_go;

  always @(posedge clkin or negedge gsr) begin
    if (!gsr) begin
      m_st = 0; m_slot = 0; m_fc = 0; m_score = 0;
      m_valid = 0; m_clr = 0; m_hit = 0; m_ovr = 0; m_go = 0;
    end else begin
      m_clr = 0;
      if (m_st == 0 || m_st == 3) begin
        if (start_btn) begin
          m_st = 1; m_clr = 1; m_score = 0; m_hit = 0; m_fc = 0; m_ovr = 0; m_go = 0;
        end
      end else if (m_st == 1) begin
        if (vblank_start && (m_hit || collision)) begin
          m_st = 3; m_go = 1;
        end else begin
          if (collision) m_hit = 1;
          if (vblank_start) begin
            m_fc = (m_fc + 1) % FD;
            if (m_fc == 0) begin m_st = 2; m_slot = 0; m_valid = 1; end
          end
        end
      end else begin
        if (collision)    m_hit = 1;
        if (vblank_start) m_ovr = 1;
        if (upd_ready) begin
          if (m_slot == N - 1) begin
            m_valid = 0; m_st = 1;
            m_score = (m_score >= 65535) ? 65535 : m_score + 1;
          end else m_slot++;
        end
      end
    end
  end

  // per-cycle output comparison and accepted-slot ordering
  int exp_acc = 0;
  always @(negedge clkin) begin
    chk("state", game_state, m_st);
    chk("valid", upd_valid, m_valid);
    chk("clear", clear_objs, m_clr);
    chk("over", game_over, m_go);
    chk("score", score, m_score);
    chk("overrun", overrun, m_ovr);
    if (m_valid) chk("slot", upd_slot, m_slot);
    if (!gsr) exp_acc = 0;
    else if (upd_valid && upd_ready) begin
      chk("acc_order", upd_slot, exp_acc);
      exp_acc = (exp_acc + 1) % N;
    end
  end

  task automatic tick();
    @(posedge clkin); #1;
  endtask

  task automatic pulse_vb();
    vblank_start = 1'b1; tick(); vblank_start = 1'b0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1; tick(); start_btn = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_state", game_state, 0);
    chk("rst_valid", upd_valid, 0);
    chk("rst_score", score, 0);
    gsr = 1'b1;
    tick();

    // start: one-cycle clear pulse, into PLAY
    pulse_start();
    chk("start_clr", clear_objs, 1);
    chk("start_state", game_state, 1);
    chk("start_score", score, 0);
    tick();
    chk("start_clr_end", clear_objs, 0);

    // two vblanks per update round, four back-to-back slots
    upd_ready = 1'b1;
    pulse_vb();
    tick();
    chk("div_no_upd", upd_valid, 0);
    pulse_vb();
    for (int i = 0; i < N; i++) begin
      chk("rnd_valid", upd_valid, 1);
      chk("rnd_slot", upd_slot, i);
      tick();
    end
    chk("rnd_state", game_state, 1);
    chk("rnd_score", score, 1);
    chk("rnd_done", upd_valid, 0);

    // stall on slot 1, with a vblank landing mid-stall
    pulse_vb();
    pulse_vb();
    tick();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_slot", upd_slot, 1);
      chk("stall_valid", upd_valid, 1);
      if (i == 2) vblank_start = 1'b1;
      tick();
      vblank_start = 1'b0;
    end
    upd_ready = 1'b1;
    tick();
    chk("stall_adv", upd_slot, 2);
    repeat (2) tick();
    chk("stall_state", game_state, 1);
    chk("stall_score", score, 2);
    chk("stall_ovr", overrun, 1);

    // collision mid-frame ends the game at the next vblank
    collision = 1'b1; tick(); collision = 1'b0;
    repeat (2) tick();
    pulse_vb();
    chk("hit_state", game_state, 3);
    chk("hit_over", game_over, 1);
    for (int i = 0; i < 4; i++) begin
      pulse_vb();
      chk("over_novalid", upd_valid, 0);
    end
    pulse_start();
    chk("restart_state", game_state, 1);
    chk("restart_score", score, 0);
    chk("restart_clr", clear_objs, 1);
    chk("restart_ovr", overrun, 0);

    // score saturation from a preloaded near-max value
    @(negedge clkin); #2;
    force dut.score = 16'hFFFE;
    m_score = 16'hFFFE;
    #1 release dut.score;
    @(posedge clkin); #1;
    for (int r = 0; r < 3; r++) begin
      pulse_vb();
      pulse_vb();
      repeat (N + 1) tick();
    end
    chk("sat_score", score, 16'hFFFF);

    // asynchronous reset mid-update drops valid without a clock edge
    upd_ready = 1'b0;
    pulse_vb();
    pulse_vb();
    chk("arst_pre_valid", upd_valid, 1);
    #2 gsr = 1'b0;
    #1;
    chk("arst_valid", upd_valid, 0);
    chk("arst_state", game_state, 0);
    tick();
    gsr = 1'b1;
    upd_ready = 1'b1;
    for (int i = 0; i < 3; i++) pulse_vb();
    chk("arst_idle", game_state, 0);

    // random play against the model
    for (int c = 0; c < 4000; c++) begin
      start_btn    = ($urandom_range(9) == 0);
      vblank_start = ($urandom_range(5) == 0);
      collision    = ($urandom_range(59) == 0);
      upd_ready    = ($urandom_range(3) != 0);
      tick();
    end
    start_btn = 1'b0; vblank_start = 1'b0; collision = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
